// File: rtl/instr_step_fifo.sv
// Instruction injection buffer feeding the core fetch input.
// Words are queued through a write port and issued one at a time under
// HOLD / STEP / RUN / LOOP control with a valid/ready handshake.
// LOOP mode recirculates each issued word back into the tail of the buffer.
module instr_step_fifo #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 16,
  parameter int               AW       = 4,
  parameter logic [WIDTH-1:0] NOP_WORD = 16'h0800,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_out,
  output logic             instr_valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam logic [1:0]       MODE_HOLD = 2'b00;
  localparam logic [1:0]       MODE_STEP = 2'b01;
  localparam logic [1:0]       MODE_RUN  = 2'b10;
  localparam logic [1:0]       MODE_LOOP = 2'b11;
  localparam logic [AW:0]      CNT_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]      CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [CNT_W-1:0] ISS_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] ISS_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW:0]      count_r;
  logic             full_r;
  logic             empty_r;
  logic             overflow_r;
  logic [CNT_W-1:0] issued_r;
  state_t           state_r;
  logic             step_q_r;
  logic             valid_r;
  logic [WIDTH-1:0] out_r;

  logic             step_rise_s;
  logic             is_loop_s;
  logic             wr_accept_s;
  logic             pop_s;
  logic             recirc_s;
  logic             free_s;
  logic             mem_we_s;
  logic [WIDTH-1:0] mem_wdata_s;
  logic [AW:0]      count_nxt_s;
  logic [AW-1:0]    rd_sel_s;
  logic [WIDTH-1:0] rd_data_s;
  state_t           next_state_s;
  logic [WIDTH-1:0] out_nxt_s;

  assign instr_out   = out_r;
  assign instr_valid = valid_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign count       = count_r;
  assign overflow    = overflow_r;
  assign issued_cnt  = issued_r;

  // Datapath control: write acceptance, handshake, recirculation and read-ahead with write bypass.
  always_comb begin
    step_rise_s = step & ~step_q_r;
    is_loop_s   = (mode == MODE_LOOP);
    wr_accept_s = wr_en & ~full_r & ~is_loop_s;
    pop_s       = (state_r == ST_PRESENT) & instr_ready;
    recirc_s    = pop_s & is_loop_s;
    free_s      = pop_s & ~is_loop_s;
    mem_we_s    = (wr_accept_s | recirc_s) & ~clr;
    mem_wdata_s = recirc_s ? out_r : wr_data;
    count_nxt_s = count_r + (AW+1)'(wr_accept_s) - (AW+1)'(free_s);
    rd_sel_s    = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    // The word due next may be landing in memory on this very edge.
    if (mem_we_s && (wr_ptr_r == rd_sel_s)) begin
      rd_data_s = mem_wdata_s;
    end else begin
      rd_data_s = mem_r[rd_sel_s];
    end
  end

  // Issue FSM next state and the word to present after this edge.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((count_r != CNT_ZERO) &&
            ((mode == MODE_RUN) || (mode == MODE_LOOP) ||
             ((mode == MODE_STEP) && step_rise_s))) begin
          next_state_s = ST_PRESENT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (!pop_s) begin
          next_state_s = ST_PRESENT;
        end else if (((mode == MODE_RUN) || (mode == MODE_LOOP)) &&
                     (count_nxt_s != CNT_ZERO)) begin
          next_state_s = ST_PRESENT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase

    if (next_state_s == ST_PRESENT) begin
      if ((state_r == ST_PRESENT) && !pop_s) begin
        out_nxt_s = out_r;
      end else begin
        out_nxt_s = rd_data_s;
      end
    end else begin
      out_nxt_s = NOP_WORD;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wr_ptr_r] <= mem_wdata_s;
    end
  end

  // Step input history for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q_r <= 1'b0;
    end else begin
      step_q_r <= step;
    end
  end

  // Pointers, occupancy, status flags, issue counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r   <= PTR_ZERO;
      wr_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
      issued_r   <= ISS_ZERO;
      state_r    <= ST_IDLE;
      valid_r    <= 1'b0;
      out_r      <= NOP_WORD;
    end else if (clr) begin
      rd_ptr_r   <= PTR_ZERO;
      wr_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
      issued_r   <= ISS_ZERO;
      state_r    <= ST_IDLE;
      valid_r    <= 1'b0;
      out_r      <= NOP_WORD;
    end else begin
      if (wr_accept_s || recirc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        issued_r <= issued_r + ISS_ONE;
      end
      if (wr_en && !wr_accept_s) begin
        overflow_r <= 1'b1;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      empty_r <= (count_nxt_s == CNT_ZERO);
      state_r <= next_state_s;
      valid_r <= (next_state_s == ST_PRESENT);
      out_r   <= out_nxt_s;
    end
  end

endmodule

// File: tb/tb_instr_step_fifo.sv
// Directed bench for instr_step_fifo: expected issue words are queued when
// loaded and compared at every observed valid/ready handshake.
module tb_instr_step_fifo;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [1:0]  mode;
  logic        step;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] issued_cnt;

  logic [15:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          hs     = 0;

  instr_step_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .mode       (mode),
    .step       (step),
    .instr_ready(instr_ready),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .issued_cnt (issued_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Checks the handshake about to happen (or the idle NOP), then advances one clock.
  task automatic cyc();
    logic [15:0] e;
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      hs++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_issue observed=0x%0h expected=none", instr_out);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("issue_word", {16'h0000, instr_out}, {16'h0000, e});
      end
    end else if (instr_valid === 1'b0) begin
      chk("idle_nop", {16'h0000, instr_out}, {16'h0000, NOP});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write(input logic [15:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_data = 16'h0000;
    mode = 2'b00; step = 1'b0; instr_ready = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_out", instr_out, NOP);
    chk("rst_count", count, 5'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_issued", issued_cnt, 16'd0);
    rst = 1'b1;
    cyc();

    // HOLD: words load but nothing is issued
    write(16'h6901);
    write(16'h6BB0);
    repeat (3) cyc();
    chk("hold_count", count, 5'd2);
    chk("hold_valid", instr_valid, 1'b0);
    chk("hold_out", instr_out, NOP);

    // STEP: one word per rising edge of step; third edge finds buffer empty
    exp_q.push_back(16'h6901);
    exp_q.push_back(16'h6BB0);
    mode = 2'b01;
    instr_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      repeat (3) cyc();
      step = 1'b0;
      repeat (3) cyc();
    end
    chk("step_issued", issued_cnt, 16'd2);
    chk("step_empty", empty, 1'b1);
    chk("step_drained", exp_q.size(), 0);
    chk("step_valid", instr_valid, 1'b0);

    // RUN with backpressure
    pulse_clr();
    chk("clr_issued", issued_cnt, 16'd0);
    mode = 2'b00;
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      write(16'h1001 + 16'(i));
      exp_q.push_back(16'h1001 + 16'(i));
    end
    mode = 2'b10;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", instr_valid, 1'b1);
      chk("bp_hold", instr_out, 16'h1001);
      cyc();
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("run_b2b_valid", instr_valid, 1'b1);
      cyc();
    end
    chk("run_idle", instr_valid, 1'b0);
    chk("run_issued", issued_cnt, 16'd4);
    chk("run_drained", exp_q.size(), 0);

    // Fill past capacity, then drain in order
    mode = 2'b00;
    instr_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      write(16'h2000 + 16'(i));
      if (i < 16) exp_q.push_back(16'h2000 + 16'(i));
    end
    chk("full_flag", full, 1'b1);
    chk("full_count", count, 5'd16);
    chk("full_ovf", overflow, 1'b1);
    chk("full_empty", empty, 1'b0);
    mode = 2'b10;
    instr_ready = 1'b1;
    repeat (24) cyc();
    chk("drain_empty", empty, 1'b1);
    chk("drain_all", exp_q.size(), 0);
    chk("drain_issued", issued_cnt, 16'd20);
    chk("ovf_sticky", overflow, 1'b1);

    // Pop of the last word while the next one is being written
    pulse_clr();
    chk("clr_ovf", overflow, 1'b0);
    instr_ready = 1'b0;
    write(16'h4444);
    cyc();
    chk("byp_valid", instr_valid, 1'b1);
    exp_q.push_back(16'h4444);
    exp_q.push_back(16'h5555);
    instr_ready = 1'b1;
    write(16'h5555);
    repeat (3) cyc();
    chk("byp_drained", exp_q.size(), 0);
    chk("byp_empty", empty, 1'b1);

    // LOOP replay of three words for seven issues
    pulse_clr();
    mode = 2'b00;
    instr_ready = 1'b0;
    write(16'h6901);
    write(16'h3360);
    write(16'hDB60);
    for (int r = 0; r < 7; r++) begin
      case (r % 3)
        0:       exp_q.push_back(16'h6901);
        1:       exp_q.push_back(16'h3360);
        default: exp_q.push_back(16'hDB60);
      endcase
    end
    mode = 2'b11;
    hs = 0;
    for (int n = 0; n < 40 && hs < 7; n++) begin
      instr_ready = 1'b1;
      cyc();
    end
    instr_ready = 1'b0;
    chk("loop_issues", hs, 7);
    chk("loop_drained", exp_q.size(), 0);
    chk("loop_count", count, 5'd3);
    chk("loop_issued", issued_cnt, 16'd7);
    chk("loop_ovf_before", overflow, 1'b0);
    write(16'hFFFF);
    chk("loop_wr_ovf", overflow, 1'b1);
    chk("loop_wr_count", count, 5'd3);

    // clr while a word is held on the output, with a write in the same cycle
    chk("pre_clr_valid", instr_valid, 1'b1);
    chk("pre_clr_out", instr_out, 16'h3360);
    clr = 1'b1;
    wr_en = 1'b1;
    wr_data = 16'h7777;
    cyc();
    clr = 1'b0;
    wr_en = 1'b0;
    chk("clr_valid", instr_valid, 1'b0);
    chk("clr_count", count, 5'd0);
    chk("clr_issued0", issued_cnt, 16'd0);
    chk("clr_ovf0", overflow, 1'b0);
    chk("clr_empty", empty, 1'b1);

    // Asynchronous reset in the middle of a handshake
    mode = 2'b00;
    write(16'h1234);
    write(16'h5678);
    mode = 2'b10;
    cyc();
    exp_q.push_back(16'h1234);
    instr_ready = 1'b1;
    cyc();
    chk("mid_valid", instr_valid, 1'b1);
    chk("mid_issued", issued_cnt, 16'd1);
    rst = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 1'b0);
    chk("arst_out", instr_out, NOP);
    chk("arst_count", count, 5'd0);
    chk("arst_issued", issued_cnt, 16'd0);
    chk("arst_empty", empty, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    instr_ready = 1'b0;
    mode = 2'b00;
    cyc();
    chk("post_rst_count", count, 5'd0);
    chk("post_rst_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_step_fifo.md
Name: instr_step_fifo

Overview:
Parametrised instruction injection buffer that feeds instruction words into the CPU core's instruction input. It replaces hand-stepped switch stimulus with a buffered, handshaked source. Words are loaded through a write port. They are issued to the core one at a time under one of four modes: hold, single-step, free-run, or loop (recirculating replay). It sits between a loader (switches, UART receiver or bench) and the core fetch input.

Parameters:
WIDTH, 16, instruction word width
DEPTH, 16, buffer entries; power of two, at least 2
AW, 4, pointer width; must equal log2(DEPTH)
NOP_WORD, 16'h0800, value driven on instr_out whenever instr_valid is low
CNT_W, 16, width of issued-instruction counter

Ports:
clk  in  1  system clock, rising-edge active
rst  in  1  asynchronous active-low reset
clr  in  1  synchronous flush
wr_en  in  1  write request
wr_data  in  WIDTH  word to enqueue
mode  in  2  00 HOLD, 01 STEP, 10 RUN, 11 LOOP
step  in  1  level input; each rising edge requests one issue in STEP mode
instr_ready  in  1  core accepts instr_out this cycle
instr_out  out  WIDTH  instruction presented to core
instr_valid  out  1  instr_out is valid
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  AW+1  occupied entries
overflow  out  1  sticky: a write was dropped
issued_cnt  out  CNT_W  handshakes completed since reset or clr, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst low, async): instr_valid 0, instr_out NOP_WORD, pointers 0, count 0, empty 1, full 0, overflow 0, issued_cnt 0, state IDLE, step_q 0.
  - Memory contents are not reset.
- Storage: DEPTH x WIDTH register array; rd_ptr/wr_ptr wrap modulo DEPTH; count, full and empty are registered.
- Write accepted when wr_en and not full and mode != LOOP: the word is stored at wr_ptr and wr_ptr increments.
  - A dropped write (full, or LOOP mode) sets overflow; it clears only on rst or clr.
- Step edge: step_q registers step; step_rise = step & ~step_q.
- FSM, two states:
  - IDLE: instr_valid 0, instr_out NOP_WORD. Goes to PRESENT next cycle if count != 0 and one of:
    - mode RUN
    - mode LOOP
    - mode STEP with step_rise
    Otherwise stays IDLE. HOLD never leaves IDLE.
  - PRESENT: instr_valid 1, instr_out = mem[rd_ptr].
    - Without instr_ready: output held stable; it is never retracted except by clr or rst.
    - On instr_ready: issued_cnt increments and rd_ptr increments.
    - In non-LOOP modes the word is freed (count decrements).
    - In LOOP mode the word is rewritten at wr_ptr, wr_ptr increments and count is unchanged.
    - Next state after handshake is PRESENT if mode (sampled that cycle) is RUN or LOOP and the post-pop count != 0; otherwise IDLE.
    - STEP therefore issues exactly one word per edge.
    - step_rise during PRESENT is ignored; edges are not queued.
- Mode change during PRESENT takes effect only after the pending handshake.
- Simultaneous accepted write and non-LOOP pop: count unchanged, both pointers advance.
  - Writing into a full buffer is dropped even when a pop occurs the same cycle.
- Latency:
  - step_rise sampled at edge n -> instr_valid high after edge n+1.
  - First write into an empty buffer in RUN mode, at edge n -> count 1 after edge n, instr_valid high after edge n+1.
  - Back-to-back issue in RUN with instr_ready held high: one word per cycle.
- clr (synchronous, priority over everything except rst):
  - pointers, count, issued_cnt and overflow go to 0; state goes to IDLE; instr_valid drops next cycle.
  - A write presented in the same cycle as clr is discarded.
- Reset asserted mid-handshake: all outputs take reset values immediately; no partial pop.

Test Plan:
- Reset/idle: hold rst low, then release with mode HOLD; write 0x6901, 0x6BB0 -> count 2, instr_valid stays 0, instr_out 0x0800.
- Single-step: mode STEP, instr_ready 1, three step pulses -> exactly 0x6901 then 0x6BB0 issued, third pulse ignored (empty), issued_cnt 2, empty 1.
- Run with backpressure: load 4 words, mode RUN, instr_ready low 3 cycles then high -> first word held stable 3 cycles, then 4 words on 4 consecutive cycles, issued_cnt 4.
- Full/overflow: write DEPTH+1 words -> full 1, count 16, overflow 1; later pops return words 0..15 in order.
- Loop replay: load 0x6901, 0x3360, 0xDB60, mode LOOP, instr_ready 1 for 7 cycles -> sequence 1,2,3,1,2,3,1; count stays 3; wr_en in LOOP sets overflow.
- clr mid-PRESENT: instr_ready 0 with valid high, pulse clr -> next cycle instr_valid 0, count 0, issued_cnt 0, overflow 0; async rst low mid-run -> outputs immediately reset.
